multi_pattern_page_scan: RTL and testbench

MULTI_PATTERN_PAGE_SCAN -- requirements
Module: multi_pattern_page_scan

---
 rtl/multi_pattern_page_scan.sv | 173 +++++++++++++++++
 tb/tb_multi_pattern_page_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_pattern_page_scan.sv
// multi_pattern_page_scan
// Scans a latched page array one block (PPB pages) per cycle against a set of
// enabled patterns and builds a compacted, ascending list of matching page
// numbers together with a per-page hit mask and a hit count.
module multi_pattern_page_scan #(
    parameter int P_SIZE  = 12,
    parameter int PPB     = 8,
    parameter int NOB     = 3,
    parameter int NUM_PAT = 4,
    localparam int NOP    = PPB * NOB,
    localparam int IDX_W  = (NOP > 1) ? $clog2(NOP) : 1,
    localparam int CNT_W  = $clog2(NOP + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NOP*P_SIZE-1:0]    a,
    input  logic [NUM_PAT*P_SIZE-1:0] pat,
    input  logic [NUM_PAT-1:0]       pat_en,
    output logic                     busy,
    output logic                     done,
    output logic [NOP*IDX_W-1:0]     tpn_list,
    output logic [CNT_W-1:0]         tpn_count,
    output logic [NOP-1:0]           hit_mask
);

    localparam int BLK_W = (NOB > 1) ? $clog2(NOB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [BLK_W-1:0]          r_blk;
    logic                      w_last_blk;

    logic [NOP*P_SIZE-1:0]     r_a;
    logic [NUM_PAT*P_SIZE-1:0] r_pat;
    logic [NUM_PAT-1:0]        r_pat_en;

    logic [NOP*IDX_W-1:0]      r_list;
    logic [CNT_W-1:0]          r_cnt;
    logic [NOP-1:0]            r_mask;
    logic                      r_busy;
    logic                      r_done;

    logic [NOP*IDX_W-1:0]      w_list_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [NOP-1:0]            w_mask_nxt;
    logic [PPB-1:0]            w_blk_hit;
    logic [P_SIZE-1:0]         w_page;
    int                        w_base;

    assign w_last_blk = (r_blk == BLK_W'(NOB - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one SCAN cycle per block, then a single DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last_blk) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Compare the current block against all enabled patterns and append the
    // true pages, lowest first, behind the entries already collected
    always_comb begin
        w_list_nxt = r_list;
        w_cnt_nxt  = r_cnt;
        w_mask_nxt = r_mask;
        w_blk_hit  = '0;
        w_page     = '0;
        w_base     = int'(r_blk) * PPB;
        for (int unsigned p = 0; p < PPB; p++) begin
            w_page = r_a[(w_base + int'(p)) * P_SIZE +: P_SIZE];
            // OR across patterns so duplicate patterns yield a single hit
            for (int unsigned j = 0; j < NUM_PAT; j++) begin
                if (r_pat_en[j] && (w_page == r_pat[j*P_SIZE +: P_SIZE])) begin
                    w_blk_hit[p] = 1'b1;
                end
            end
            if (w_blk_hit[p]) begin
                w_list_nxt[int'(w_cnt_nxt) * IDX_W +: IDX_W] = IDX_W'(w_base + int'(p));
                w_mask_nxt[w_base + int'(p)]                 = 1'b1;
                w_cnt_nxt                                    = w_cnt_nxt + CNT_W'(1);
            end
        end
    end

    // Operand latch, block index and result accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk    <= '0;
            r_a      <= '0;
            r_pat    <= '0;
            r_pat_en <= '0;
            r_list   <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_pat    <= pat;
                        r_pat_en <= pat_en;
                        r_list   <= '0;
                        r_cnt    <= '0;
                        r_mask   <= '0;
                        r_blk    <= '0;
                    end
                end
                S_SCAN: begin
                    r_list <= w_list_nxt;
                    r_cnt  <= w_cnt_nxt;
                    r_mask <= w_mask_nxt;
                    if (!w_last_blk) begin
                        r_blk <= r_blk + BLK_W'(1);
                    end
                end
                default: begin
                    r_blk <= r_blk;
                end
            endcase
        end
    end

    // Registered status: busy trails the FSM by one cycle and done pulses
    // once, in the cycle after DONE, while the FSM is already back in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_DONE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign tpn_list  = r_list;
    assign tpn_count = r_cnt;
    assign hit_mask  = r_mask;

endmodule

// File: tb/tb_multi_pattern_page_scan.sv
// Scoreboard bench for multi_pattern_page_scan: stimulus pushes the expected
// result, a monitor pops and compares whenever done pulses.
module tb_multi_pattern_page_scan;

    localparam int P_SIZE  = 12;
    localparam int PPB     = 8;
    localparam int NOB     = 3;
    localparam int NUM_PAT = 4;
    localparam int NOP     = 24;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 5;
    localparam int AW      = NOP * P_SIZE;
    localparam int PW      = NUM_PAT * P_SIZE;
    localparam int LW      = NOP * IDX_W;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [LW-1:0]    list;
        logic [NOP-1:0]   mask;
    } res_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [AW-1:0]       a;
    logic [PW-1:0]       pat;
    logic [NUM_PAT-1:0]  pat_en;
    logic                busy;
    logic                done;
    logic [LW-1:0]       tpn_list;
    logic [CNT_W-1:0]    tpn_count;
    logic [NOP-1:0]      hit_mask;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;

    multi_pattern_page_scan #(
        .P_SIZE (P_SIZE),
        .PPB    (PPB),
        .NOB    (NOB),
        .NUM_PAT(NUM_PAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .pat      (pat),
        .pat_en   (pat_en),
        .busy     (busy),
        .done     (done),
        .tpn_list (tpn_list),
        .tpn_count(tpn_count),
        .hit_mask (hit_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected result
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("tpn_count", LW'(tpn_count), LW'(e.cnt));
                    chk("tpn_list",  tpn_list,       e.list);
                    chk("hit_mask",  LW'(hit_mask),  LW'(e.mask));
                end
            end
        end
    end

    function automatic logic [AW-1:0] fill(input logic [P_SIZE-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < NOP; i++) r[i*P_SIZE +: P_SIZE] = v;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run(input logic [AW-1:0] arr, input logic [PW-1:0] pv,
                       input logic [NUM_PAT-1:0] en, input res_t exp,
                       input bit disturb, input logic [AW-1:0] arr2);
        int cyc;
        a = arr; pat = pv; pat_en = en; start = 1'b1;
        q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            a = arr2; pat_en = '1; start = 1'b1;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) chk("busy_in_scan", LW'(busy), LW'(1));
            if (cyc == 2) start = 1'b0;
        end
        chk("done_latency", LW'(cyc), LW'(4));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0]  pv, pv_dup;
        logic [AW-1:0]  arr_a, arr_all, arr_dup;
        res_t           r_a, r_all, r_a0, r_none, r_dup;

        pv     = {12'h444, 12'h333, 12'h222, 12'h111};
        pv_dup = {12'h444, 12'h333, 12'h111, 12'h111};

        arr_a = '0;
        arr_a[0*P_SIZE  +: P_SIZE] = 12'h111;
        arr_a[5*P_SIZE  +: P_SIZE] = 12'h222;
        arr_a[23*P_SIZE +: P_SIZE] = 12'h444;
        arr_all = fill(12'h333);
        arr_dup = '0;
        arr_dup[9*P_SIZE +: P_SIZE] = 12'h111;

        r_a.cnt  = 5'd3;
        r_a.list = '0;
        r_a.list[0*IDX_W +: IDX_W] = 5'd0;
        r_a.list[1*IDX_W +: IDX_W] = 5'd5;
        r_a.list[2*IDX_W +: IDX_W] = 5'd23;
        r_a.mask = 24'h800021;

        r_all.cnt  = 5'd24;
        r_all.list = '0;
        for (int k = 0; k < NOP; k++) r_all.list[k*IDX_W +: IDX_W] = IDX_W'(k);
        r_all.mask = 24'hFFFFFF;

        r_a0.cnt = 5'd1;  r_a0.list = '0;  r_a0.mask = 24'h000001;
        r_none.cnt = '0;  r_none.list = '0; r_none.mask = '0;
        r_dup.cnt = 5'd1; r_dup.list = '0; r_dup.mask = 24'h000200;
        r_dup.list[0 +: IDX_W] = 5'd9;

        rst = 1'b0; start = 1'b0; a = '0; pat = '0; pat_en = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  LW'(busy),      LW'(0));
        chk("rst_done",  LW'(done),      LW'(0));
        chk("rst_count", LW'(tpn_count), LW'(0));
        chk("rst_list",  tpn_list,       LW'(0));
        chk("rst_mask",  LW'(hit_mask),  LW'(0));
        rst = 1'b1;
        @(negedge clk);

        run(arr_a, pv, 4'hF, r_a, 1'b0, '0);
        run(arr_all, pv, 4'hF, r_all, 1'b0, '0);
        repeat (3) @(negedge clk);
        chk("hold_count", LW'(tpn_count), LW'(r_all.cnt));
        chk("hold_list",  tpn_list,       r_all.list);
        chk("hold_mask",  LW'(hit_mask),  LW'(r_all.mask));
        chk("idle_busy",  LW'(busy),      LW'(0));

        run(arr_a, pv, 4'b0001, r_a0, 1'b0, '0);
        // Back-to-back: start issued in the done cycle
        run(arr_a, pv, 4'b0000, r_none, 1'b0, '0);
        run(arr_dup, pv_dup, 4'hF, r_dup, 1'b0, '0);
        run(arr_a, pv, 4'hF, r_a, 1'b1, arr_all);

        // Reset while block 1 is being scanned; partial result discarded
        @(negedge clk);
        a = arr_all; pat = pv; pat_en = 4'hF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("partial_count", LW'(tpn_count), LW'(8));
        rst = 1'b0;
        #1;
        chk("midrst_busy",  LW'(busy),      LW'(0));
        chk("midrst_done",  LW'(done),      LW'(0));
        chk("midrst_count", LW'(tpn_count), LW'(0));
        chk("midrst_list",  tpn_list,       LW'(0));
        chk("midrst_mask",  LW'(hit_mask),  LW'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", LW'(busy), LW'(0));
        run(arr_a, pv, 4'hF, r_a, 1'b0, '0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", LW'(q.size()), LW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
